fp_align_shifter: RTL and testbench
===================================

// Module: fp_align_shifter
// PURPOSE
//  Pre-add exponent alignment for the FP32 add/sub datapath; the inverse step of the post-add normalizer.
//  Picks the operand with the larger exponent and right-shifts the other fraction by the exponent difference.
//  The shift is iterative, one bit per clock, and keeps a sticky bit in the LSB.
//  Output feeds the fraction adder; in/out use valid/ready handshakes.
// PARAMETERS
//  EXP_W   8   exponent width
//  MAN_W   24  input fraction width incl. hidden bit
//  FRAC_W  27  aligned width = MAN_W + 3 (guard, round, sticky)
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  in_valid     in   1       operands valid
//  in_ready     out  1       block can accept (state IDLE)
//  exp_a        in   EXP_W   exponent of operand A
//  exp_b        in   EXP_W   exponent of operand B
//  frac_a       in   MAN_W   fraction of A, hidden bit included
//  frac_b       in   MAN_W   fraction of B, hidden bit included
//  out_valid    out  1       aligned result valid (state DONE)
//  out_ready    in   1       consumer accepts result
//  exp_out      out  EXP_W   larger exponent (common exponent)
//  frac_big     out  FRAC_W  {larger-exp fraction, 3'b000}
//  frac_small   out  FRAC_W  aligned smaller fraction, sticky in bit 0
//  swapped      out  1       1 when B was the larger-exponent operand
// BEHAVIOUR
//  Reset: state IDLE; out_valid=0; exp_out, frac_big, frac_small, swapped all 0. in_ready=1 (decoded from state).
//  FSM: IDLE -> SHIFT -> DONE -> IDLE. in_ready=(IDLE), out_valid=(DONE).
//  Accept edge (in_valid & in_ready):
//   - swapped = exp_b > exp_a. On equal exponents, A is "big" and swapped=0.
//   - d = |exp_a - exp_b| on EXP_W bits, unsigned.
//   - Small fraction is loaded as {frac,3'b000}.
//  d==0: go to DONE directly; frac_small is unshifted.
//  d>=FRAC_W: go to DONE directly; frac_small = {26'b0, |frac_small_in}. All bits are flushed into sticky.
//  0<d<FRAC_W: go to SHIFT with cnt=d. Each SHIFT edge does:
//   - frac_small <= {1'b0, fs[FRAC_W-1:2], fs[1]|fs[0]}
//   - cnt <= cnt-1
//   - when cnt==1 before the edge, go to DONE.
//  Latency from the accept edge to out_valid: d+1 cycles for 0<d<FRAC_W, else 1 cycle.
//  DONE: outputs held stable until out_valid & out_ready, then go to IDLE.
//  in_valid is ignored outside IDLE. The block accepts no new operation in the same cycle as the DONE handoff.
//  Asynchronous reset in any state forces the reset values immediately. The in-flight operation is discarded.
//  Zero, denormal and special operands get no special handling; the upstream unpacker handles them.
// CONFIGURATION
//  ALIGN_BARREL_EN defined:
//   - The full sticky barrel shift is done at the accept edge and the FSM goes straight to DONE.
//   - Latency is 1 cycle for every d; results are bit-identical to the iterative path.
//  ALIGN_BARREL_EN undefined: iterative 1-bit/cycle path as above.
// STRUCTURE
//  Package fp_align_pkg holds:
//   - EXP_W, MAN_W and FRAC_W localparams
//   - GRS_W=3
//   - typedef enum align_state_t {IDLE,SHIFT,DONE}
//  Sub-module fp_sticky_shr: combinational 1-bit sticky right shift, FRAC_W wide. It is reused by the barrel path per stage.
// TESTING
//  1. exp_a=exp_b=127, fa=24'h800000, fb=24'hC00000
//     -> out_valid 1 cycle after accept, swapped=0, exp_out=127, frac_small=27'h6000000.
//  2. exp_a=127, exp_b=131, fa=24'h800001, fb=24'h800000
//     -> swapped=1, exp_out=131, frac_big=27'h4000000, frac_small=27'h0400001, latency 5.
//  3. exp_a=200, exp_b=100, fb=24'h800000
//     -> frac_small=27'h0000001, latency 1. Repeat with fb=0 -> frac_small=0.
//  4. Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid
//     -> outputs stable, in_ready=0, no new capture.
//  5. d=20 with rst_n low 5 cycles after accept
//     -> out_valid=0 and outputs 0 immediately; in_ready=1 after release.
//  6. With ALIGN_BARREL_EN, rerun scenarios 1-3
//     -> identical values, latency 1 for each.

Source files
------------

// File: rtl/fp_align_pkg.sv
// Shared constants and state type for the FP32 pre-add exponent alignment block.
package fp_align_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 24;
    localparam int unsigned GRS_W  = 3;
    localparam int unsigned FRAC_W = MAN_W + GRS_W;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } align_state_t;

endpackage

// File: rtl/fp_sticky_shr.sv
// Combinational 1-bit right shift that folds the shifted-out bit into a sticky LSB.
module fp_sticky_shr
    import fp_align_pkg::*;
(
    input  logic [FRAC_W-1:0] din,
    output logic [FRAC_W-1:0] dout
);

    // Bit 0 accumulates everything that has ever been shifted past it.
    assign dout = {1'b0, din[FRAC_W-1:2], din[1] | din[0]};

endmodule

// File: rtl/fp_align_shifter.sv
// FP32 add/sub exponent alignment: selects the larger-exponent operand and right-shifts
// the other fraction by the exponent difference with a sticky LSB.
// Default build shifts one bit per clock; defining ALIGN_BARREL_EN does the whole
// sticky shift at the accept edge (latency 1, bit-identical results).
module fp_align_shifter
    import fp_align_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  exp_a,
    input  logic [EXP_W-1:0]  exp_b,
    input  logic [MAN_W-1:0]  frac_a,
    input  logic [MAN_W-1:0]  frac_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  exp_out,
    output logic [FRAC_W-1:0] frac_big,
    output logic [FRAC_W-1:0] frac_small,
    output logic              swapped
);

    localparam logic [EXP_W-1:0] FRAC_W_E = EXP_W'(FRAC_W);
    localparam logic [EXP_W-1:0] ONE_E    = EXP_W'(1);

    align_state_t      state;
    logic [EXP_W-1:0]  cnt;

    logic              swap_in;
    logic [EXP_W-1:0]  diff;
    logic [EXP_W-1:0]  exp_big_in;
    logic [MAN_W-1:0]  big_in;
    logic [MAN_W-1:0]  small_in;
    logic [FRAC_W-1:0] small_ld;
    logic [FRAC_W-1:0] small_flush;
    logic              far;
    logic [FRAC_W-1:0] shr_out;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Operand selection: ties keep A as the big operand.
    always_comb begin
        swap_in     = (exp_b > exp_a);
        diff        = swap_in ? (exp_b - exp_a) : (exp_a - exp_b);
        exp_big_in  = swap_in ? exp_b : exp_a;
        big_in      = swap_in ? frac_b : frac_a;
        small_in    = swap_in ? frac_a : frac_b;
        small_ld    = {small_in, {GRS_W{1'b0}}};
        small_flush = {{(FRAC_W-1){1'b0}}, |small_in};
        far         = (diff >= FRAC_W_E);
    end

    // Iterative shifter stage acting on the held small fraction.
    fp_sticky_shr u_shr (
        .din  (frac_small),
        .dout (shr_out)
    );

`ifdef ALIGN_BARREL_EN
    logic [FRAC_W-1:0] stage [FRAC_W];
    logic [FRAC_W-1:0] barrel_out;

    assign stage[0] = small_ld;

    // Chain of sticky stages; stage[k] is the input shifted right by k.
    for (genvar i = 0; i < FRAC_W - 1; i++) begin : g_stage
        fp_sticky_shr u_stage (
            .din  (stage[i]),
            .dout (stage[i+1])
        );
    end

    // Pick the stage matching the exponent difference, or flush when out of range.
    always_comb begin
        barrel_out = small_flush;
        for (int k = 0; k < FRAC_W; k++) begin
            if (diff == EXP_W'(k)) begin
                barrel_out = stage[k];
            end
        end
    end
`endif

    // Control FSM with registered result fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            exp_out    <= '0;
            frac_big   <= '0;
            frac_small <= '0;
            swapped    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        swapped  <= swap_in;
                        exp_out  <= exp_big_in;
                        frac_big <= {big_in, {GRS_W{1'b0}}};
`ifdef ALIGN_BARREL_EN
                        frac_small <= barrel_out;
                        state      <= DONE;
`else
                        if (diff == '0) begin
                            frac_small <= small_ld;
                            state      <= DONE;
                        end else if (far) begin
                            frac_small <= small_flush;
                            state      <= DONE;
                        end else begin
                            frac_small <= small_ld;
                            cnt        <= diff;
                            state      <= SHIFT;
                        end
`endif
                    end
                end
                SHIFT: begin
                    frac_small <= shr_out;
                    cnt        <= cnt - ONE_E;
                    if (cnt == ONE_E) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_align_shifter.sv
// Self-checking bench for fp_align_shifter: directed cases plus randomized operands
// against an arithmetic reference model.
module tb_fp_align_shifter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [23:0] frac_a;
    logic [23:0] frac_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic [26:0] frac_big;
    logic [26:0] frac_small;
    logic        swapped;

    int n_checks;
    int n_fail;
    int last_lat;

    fp_align_shifter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exp_a      (exp_a),
        .exp_b      (exp_b),
        .frac_a     (frac_a),
        .frac_b     (frac_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exp_out    (exp_out),
        .frac_big   (frac_big),
        .frac_small (frac_small),
        .swapped    (swapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Exact sticky right shift: value shifted by d, LSB ORed with any nonzero lost bits.
    function automatic longint model_small(input int sm, input int d);
        longint x;
        longint r;
        x = longint'(sm) << 3;
        if (d >= 27) return (sm != 0) ? 64'd1 : 64'd0;
        r = x >> d;
        if ((x & ((longint'(1) << d) - 1)) != 0) r = r | 1;
        return r;
    endfunction

    function automatic int model_lat(input int d);
`ifdef ALIGN_BARREL_EN
        return 1;
`else
        if (d == 0 || d >= 27) return 1;
        return d + 1;
`endif
    endfunction

    task automatic start_op(input int ea, input int eb, input int fa, input int fb);
        @(negedge clk);
        check_eq("in_ready_before_accept", in_ready, 1);
        exp_a    = ea[7:0];
        exp_b    = eb[7:0];
        frac_a   = fa[23:0];
        frac_b   = fb[23:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency counts edges from the accept edge (inclusive) until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) check_eq("out_valid_timeout", out_valid, 1);
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("out_valid_after_pop", out_valid, 0);
        check_eq("in_ready_after_pop", in_ready, 1);
    endtask

    task automatic run_op(input string tag, input int ea, input int eb, input int fa, input int fb);
        int swp;
        int d;
        int big;
        int sm;
        swp = (eb > ea) ? 1 : 0;
        d   = swp ? (eb - ea) : (ea - eb);
        big = swp ? fb : fa;
        sm  = swp ? fa : fb;
        start_op(ea, eb, fa, fb);
        wait_done(last_lat);
        check_eq({tag, "_lat"}, last_lat, model_lat(d));
        check_eq({tag, "_swapped"}, swapped, swp);
        check_eq({tag, "_exp_out"}, exp_out, swp ? eb : ea);
        check_eq({tag, "_frac_big"}, frac_big, longint'(big) << 3);
        check_eq({tag, "_frac_small"}, frac_small, model_small(sm, d));
    endtask

    logic [7:0]  snap_exp;
    logic [26:0] snap_big;
    logic [26:0] snap_small;
    logic        snap_swp;

    initial begin
        int ea;
        int eb;
        int fa;
        int fb;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_a     = '0;
        exp_b     = '0;
        frac_a    = '0;
        frac_b    = '0;
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_exp_out", exp_out, 0);
        check_eq("rst_frac_big", frac_big, 0);
        check_eq("rst_frac_small", frac_small, 0);
        check_eq("rst_swapped", swapped, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Equal exponents.
        run_op("t1", 127, 127, 24'h800000, 24'hC00000);
        check_eq("t1_small_const", frac_small, 27'h6000000);
        check_eq("t1_lat_const", last_lat, 1);
        pop();

        // B larger by 4, sticky from A's LSB.
        run_op("t2", 127, 131, 24'h800001, 24'h800000);
        check_eq("t2_swapped_const", swapped, 1);
        check_eq("t2_exp_const", exp_out, 131);
        check_eq("t2_big_const", frac_big, 27'h4000000);
        check_eq("t2_small_const", frac_small, 27'h0400001);
`ifdef ALIGN_BARREL_EN
        check_eq("t2_lat_const", last_lat, 1);
`else
        check_eq("t2_lat_const", last_lat, 5);
`endif
        pop();

        // Difference beyond the aligned width flushes into sticky.
        run_op("t3a", 200, 100, 24'h800000, 24'h800000);
        check_eq("t3a_small_const", frac_small, 27'h0000001);
        check_eq("t3a_lat_const", last_lat, 1);
        pop();
        run_op("t3b", 200, 100, 24'h800000, 24'h000000);
        check_eq("t3b_small_const", frac_small, 27'h0000000);
        pop();

        // Backpressure in DONE with in_valid pulsing.
        run_op("t4", 130, 128, 24'hABCDEF, 24'h812345);
        snap_exp   = exp_out;
        snap_big   = frac_big;
        snap_small = frac_small;
        snap_swp   = swapped;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            exp_a    = 8'd10;
            exp_b    = 8'd250;
            frac_a   = 24'h111111;
            frac_b   = 24'h222222;
            @(posedge clk);
            #1;
            check_eq("t4_in_ready", in_ready, 0);
            check_eq("t4_out_valid", out_valid, 1);
            check_eq("t4_exp_hold", exp_out, snap_exp);
            check_eq("t4_big_hold", frac_big, snap_big);
            check_eq("t4_small_hold", frac_small, snap_small);
            check_eq("t4_swp_hold", swapped, snap_swp);
        end
        // Handoff cycle with in_valid high must not capture.
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("t4_handoff_in_ready", in_ready, 1);
        check_eq("t4_handoff_out_valid", out_valid, 0);
        check_eq("t4_handoff_exp", exp_out, snap_exp);
        check_eq("t4_handoff_swp", swapped, snap_swp);
        @(posedge clk);
        #1;
        check_eq("t4_no_capture", out_valid, 0);

        // Asynchronous reset mid-operation.
        start_op(150, 130, 24'h9ABCDE, 24'hFEDCBA);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_out_valid", out_valid, 0);
        check_eq("t5_in_ready", in_ready, 1);
        check_eq("t5_exp_out", exp_out, 0);
        check_eq("t5_frac_big", frac_big, 0);
        check_eq("t5_frac_small", frac_small, 0);
        check_eq("t5_swapped", swapped, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t5_release_in_ready", in_ready, 1);
        check_eq("t5_release_out_valid", out_valid, 0);

        // Randomized operands, biased toward small differences.
        for (int n = 0; n < 60; n++) begin
            ea = int'($urandom_range(0, 255));
            if (n % 4 == 0) begin
                eb = int'($urandom_range(0, 255));
            end else begin
                eb = ea + int'($urandom_range(0, 30)) - 15;
                if (eb < 0) eb = 0;
                if (eb > 255) eb = 255;
            end
            fa = int'($urandom & 32'h00FF_FFFF);
            fb = int'($urandom & 32'h00FF_FFFF);
            if (n % 3 != 0) begin
                fa = fa | 32'h0080_0000;
                fb = fb | 32'h0080_0000;
            end
            run_op("rnd", ea, eb, fa, fb);
            pop();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
